// File: rtl/dcache_store_merge_buffer_pkg.sv
// Shared store-path definitions for the L1 data cache write-combining buffer:
// default geometry and the buffer state encoding.
package dcache_store_merge_buffer_pkg;

  localparam int SMB_NLANES      = 32;  // lanes per warp request
  localparam int SMB_BLOCKWORDS  = 32;  // words per cache block
  localparam int SMB_BOFFBITS    = 5;   // word-in-block index width
  localparam int SMB_BYTESOFWORD = 4;   // bytes per word
  localparam int SMB_WORDLENGTH  = 32;  // bits per word
  localparam int SMB_BLKADDRBITS = 25;  // block address width
  localparam int SMB_TIMEOUT     = 16;  // idle cycles before forced drain

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MERGE = 2'd1,
    DRAIN = 2'd2
  } smbState_e;

endpackage

// File: rtl/dcache_line_byte_merge.sv
// Combinational lane-to-line byte merge: overlays one remapped warp store
// onto the held line and its byte mask. Lanes are visited in ascending
// order so the highest lane index wins when two lanes hit the same byte.
module dcache_line_byte_merge
  import dcache_store_merge_buffer_pkg::*;
#(
  parameter int NLANES      = SMB_NLANES,
  parameter int BLOCKWORDS  = SMB_BLOCKWORDS,
  parameter int BOFFBITS    = SMB_BOFFBITS,
  parameter int BYTESOFWORD = SMB_BYTESOFWORD,
  parameter int WORDLENGTH  = SMB_WORDLENGTH
) (
  input  logic [WORDLENGTH*BLOCKWORDS-1:0]  oldData,
  input  logic [BYTESOFWORD*BLOCKWORDS-1:0] oldMask,
  input  logic [NLANES-1:0]                 activeMask,
  input  logic [BOFFBITS*NLANES-1:0]        blockOffset,
  input  logic [BYTESOFWORD*NLANES-1:0]     wordOffset1H,
  input  logic [WORDLENGTH*NLANES-1:0]      laneData,
  output logic [WORDLENGTH*BLOCKWORDS-1:0]  newData,
  output logic [BYTESOFWORD*BLOCKWORDS-1:0] newMask
);

  localparam int BYTEBITS = WORDLENGTH / BYTESOFWORD;

  // Overlay every enabled lane byte onto the line; untouched bytes keep old contents.
  always_comb begin
    newData = oldData;
    newMask = oldMask;
    for (int l = 0; l < NLANES; l++) begin
      for (int b = 0; b < BYTESOFWORD; b++) begin
        newData[(int'(blockOffset[l*BOFFBITS +: BOFFBITS]) * BYTESOFWORD + b) * BYTEBITS +: BYTEBITS] =
          (activeMask[l] && wordOffset1H[l*BYTESOFWORD + b])
            ? laneData[l*WORDLENGTH + b*BYTEBITS +: BYTEBITS]
            : newData[(int'(blockOffset[l*BOFFBITS +: BOFFBITS]) * BYTESOFWORD + b) * BYTEBITS +: BYTEBITS];
        newMask[int'(blockOffset[l*BOFFBITS +: BOFFBITS]) * BYTESOFWORD + b] =
          newMask[int'(blockOffset[l*BOFFBITS +: BOFFBITS]) * BYTESOFWORD + b]
          | (activeMask[l] & wordOffset1H[l*BYTESOFWORD + b]);
      end
    end
  end

endmodule

// File: rtl/dcache_store_merge_buffer.sv
// Single-line write-combining buffer for the L1 data cache store path.
// Coalesces successive same-block warp stores into one line with a byte
// mask and drains it downstream on address change, full line, idle
// timeout or flush. Only in_ready_o is combinational.
module dcache_store_merge_buffer
  import dcache_store_merge_buffer_pkg::*;
#(
  parameter int NLANES      = SMB_NLANES,
  parameter int BLOCKWORDS  = SMB_BLOCKWORDS,
  parameter int BOFFBITS    = SMB_BOFFBITS,
  parameter int BYTESOFWORD = SMB_BYTESOFWORD,
  parameter int WORDLENGTH  = SMB_WORDLENGTH,
  parameter int BLKADDRBITS = SMB_BLKADDRBITS,
  parameter int TIMEOUT     = SMB_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [BLKADDRBITS-1:0]            in_blockAddr_i,
  input  logic [NLANES-1:0]                 in_activeMask_i,
  input  logic [BOFFBITS*NLANES-1:0]        in_blockOffset_i,
  input  logic [BYTESOFWORD*NLANES-1:0]     in_wordOffset1H_i,
  input  logic [WORDLENGTH*NLANES-1:0]      in_data_i,
  input  logic                              flush_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [BLKADDRBITS-1:0]            out_blockAddr_o,
  output logic [WORDLENGTH*BLOCKWORDS-1:0]  out_data_o,
  output logic [BYTESOFWORD*BLOCKWORDS-1:0] out_byteMask_o,
  output logic                              empty_o
);

  localparam int LINEBITS = WORDLENGTH * BLOCKWORDS;
  localparam int MASKBITS = BYTESOFWORD * BLOCKWORDS;
  localparam int CNTW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNTMAX = CNTW'(TIMEOUT - 1);

  smbState_e               stateQ, stateN;
  logic [BLKADDRBITS-1:0]  addrQ, addrN;
  logic [LINEBITS-1:0]     dataQ, dataN, baseData, mergedData;
  logic [MASKBITS-1:0]     maskQ, maskN, baseMask, mergedMask;
  logic [CNTW-1:0]         idleCntQ, idleCntN, cntInc;
  logic                    outValidQ, emptyQ;
  logic                    inReady, sameAddr, useReq, lineFull;

  // A fresh line (from EMPTY or a DRAIN handoff) merges onto zeros, MERGE onto the held line.
  always_comb begin
    baseData = (stateQ == MERGE) ? dataQ : {LINEBITS{1'b0}};
    baseMask = (stateQ == MERGE) ? maskQ : {MASKBITS{1'b0}};
  end

  dcache_line_byte_merge #(
    .NLANES      (NLANES),
    .BLOCKWORDS  (BLOCKWORDS),
    .BOFFBITS    (BOFFBITS),
    .BYTESOFWORD (BYTESOFWORD),
    .WORDLENGTH  (WORDLENGTH)
  ) uMerge (
    .oldData      (baseData),
    .oldMask      (baseMask),
    .activeMask   (in_activeMask_i),
    .blockOffset  (in_blockOffset_i),
    .wordOffset1H (in_wordOffset1H_i),
    .laneData     (in_data_i),
    .newData      (mergedData),
    .newMask      (mergedMask)
  );

  // Upstream handshake: a different block in MERGE is held off until the line drains.
  always_comb begin
    sameAddr = (in_blockAddr_i == addrQ);
    case (stateQ)
      EMPTY:   inReady = 1'b1;
      MERGE:   inReady = sameAddr;
      DRAIN:   inReady = out_ready_i;
      default: inReady = 1'b0;
    endcase
    useReq   = in_valid_i & inReady & (|in_activeMask_i);
    lineFull = &mergedMask;
    cntInc   = (idleCntQ == CNTMAX) ? idleCntQ : idleCntQ + CNTW'(1);
  end

  assign in_ready_o = inReady;

  // Next-state and next-line selection for the EMPTY/MERGE/DRAIN controller.
  always_comb begin
    stateN   = stateQ;
    addrN    = addrQ;
    dataN    = dataQ;
    maskN    = maskQ;
    idleCntN = idleCntQ;
    case (stateQ)
      EMPTY: begin
        if (useReq) begin
          addrN    = in_blockAddr_i;
          dataN    = mergedData;
          maskN    = mergedMask;
          idleCntN = {CNTW{1'b0}};
          stateN   = lineFull ? DRAIN : MERGE;
        end else begin
          stateN = EMPTY;
        end
      end
      MERGE: begin
        if (useReq) begin
          dataN    = mergedData;
          maskN    = mergedMask;
          idleCntN = {CNTW{1'b0}};
          stateN   = (lineFull || flush_i) ? DRAIN : MERGE;
        end else if (in_valid_i && !sameAddr) begin
          stateN = DRAIN;
        end else begin
          // Empty-mask requests fall here too: they never refresh the idle counter.
          idleCntN = cntInc;
          stateN   = (flush_i || (cntInc == CNTMAX)) ? DRAIN : MERGE;
        end
      end
      DRAIN: begin
        if (out_ready_i && useReq) begin
          addrN    = in_blockAddr_i;
          dataN    = mergedData;
          maskN    = mergedMask;
          idleCntN = {CNTW{1'b0}};
          stateN   = lineFull ? DRAIN : MERGE;
        end else if (out_ready_i) begin
          addrN    = {BLKADDRBITS{1'b0}};
          dataN    = {LINEBITS{1'b0}};
          maskN    = {MASKBITS{1'b0}};
          idleCntN = {CNTW{1'b0}};
          stateN   = EMPTY;
        end else begin
          stateN = DRAIN;
        end
      end
      default: begin
        addrN    = {BLKADDRBITS{1'b0}};
        dataN    = {LINEBITS{1'b0}};
        maskN    = {MASKBITS{1'b0}};
        idleCntN = {CNTW{1'b0}};
        stateN   = EMPTY;
      end
    endcase
  end

  // State, line and status registers; reset discards any held line without output.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= EMPTY;
      addrQ     <= {BLKADDRBITS{1'b0}};
      dataQ     <= {LINEBITS{1'b0}};
      maskQ     <= {MASKBITS{1'b0}};
      idleCntQ  <= {CNTW{1'b0}};
      outValidQ <= 1'b0;
      emptyQ    <= 1'b1;
    end else begin
      stateQ    <= stateN;
      addrQ     <= addrN;
      dataQ     <= dataN;
      maskQ     <= maskN;
      idleCntQ  <= idleCntN;
      outValidQ <= (stateN == DRAIN);
      emptyQ    <= (stateN == EMPTY);
    end
  end

  assign out_valid_o     = outValidQ;
  assign empty_o         = emptyQ;
  assign out_blockAddr_o = addrQ;
  assign out_data_o      = dataQ;
  assign out_byteMask_o  = maskQ;

endmodule

// File: tb/tb_dcache_store_merge_buffer.sv
// Directed bench for the store merge buffer: a cycle-by-cycle vector table
// plus hand sequences for timeout, full line, handoff, backpressure, reset.
module tb_dcache_store_merge_buffer;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [24:0]   in_blockAddr_i;
  logic [31:0]   in_activeMask_i;
  logic [159:0]  in_blockOffset_i;
  logic [127:0]  in_wordOffset1H_i;
  logic [1023:0] in_data_i;
  logic          flush_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [24:0]   out_blockAddr_o;
  logic [1023:0] out_data_o;
  logic [127:0]  out_byteMask_o;
  logic          empty_o;

  int passCnt = 0;
  int totalCnt = 0;

  dcache_store_merge_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_blockAddr_i(in_blockAddr_i), .in_activeMask_i(in_activeMask_i),
    .in_blockOffset_i(in_blockOffset_i), .in_wordOffset1H_i(in_wordOffset1H_i),
    .in_data_i(in_data_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_blockAddr_o(out_blockAddr_o), .out_data_o(out_data_o),
    .out_byteMask_o(out_byteMask_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [24:0] addr;
    int          lane;
    int          lane2;
    int          offs;
    logic [3:0]  oh;
    logic [31:0] dat;
    logic [31:0] dat2;
    logic        flush;
    logic        ordy;
    logic        expRdy;
    logic        expVld;
    logic        expEmpty;
    int          word;
    logic [31:0] expWord;
    logic [3:0]  expMaskW;
    int          expPop;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkVec(logic vld, logic [24:0] addr, int lane, int lane2, int offs,
                                 logic [3:0] oh, logic [31:0] dat, logic [31:0] dat2,
                                 logic flush, logic ordy, logic expRdy, logic expVld,
                                 logic expEmpty, int word, logic [31:0] expWord,
                                 logic [3:0] expMaskW, int expPop);
    vec_t v;
    v.vld = vld; v.addr = addr; v.lane = lane; v.lane2 = lane2; v.offs = offs;
    v.oh = oh; v.dat = dat; v.dat2 = dat2; v.flush = flush; v.ordy = ordy;
    v.expRdy = expRdy; v.expVld = expVld; v.expEmpty = expEmpty; v.word = word;
    v.expWord = expWord; v.expMaskW = expMaskW; v.expPop = expPop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    totalCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearIn();
    in_valid_i        = 1'b0;
    in_blockAddr_i    = 25'h0;
    in_activeMask_i   = 32'h0;
    in_blockOffset_i  = 160'h0;
    in_wordOffset1H_i = 128'h0;
    in_data_i         = 1024'h0;
    flush_i           = 1'b0;
  endtask

  task automatic setLane(input int l, input int off, input logic [3:0] oh, input logic [31:0] d);
    in_activeMask_i[l]           = 1'b1;
    in_blockOffset_i[l*5 +: 5]   = 5'(off);
    in_wordOffset1H_i[l*4 +: 4]  = oh;
    in_data_i[l*32 +: 32]        = d;
  endtask

  task automatic chkLine(input string nm, input int w, input logic [31:0] expW,
                         input logic [3:0] expM, input int expPop);
    chk({nm, "_word"}, 1024'(out_data_o[w*32 +: 32]), 1024'(expW));
    chk({nm, "_maskw"}, 1024'(out_byteMask_o[w*4 +: 4]), 1024'(expM));
    chk({nm, "_pop"}, 1024'($countones(out_byteMask_o)), 1024'(expPop));
  endtask

  // Time bound so the run always ends even if the DUT stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int riseAt;
    rst = 1'b1;
    out_ready_i = 1'b0;
    clearIn();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 1024'(out_valid_o), 1024'(1'b0));
    chk("rst_empty", 1024'(empty_o), 1024'(1'b1));
    chk("rst_data", out_data_o, 1024'h0);
    chk("rst_mask", 1024'(out_byteMask_o), 1024'h0);
    chk("rst_addr", 1024'(out_blockAddr_o), 1024'h0);
    @(negedge clk);
    rst = 1'b0;

    // vld addr lane lane2 off oh dat dat2 flush ordy | rdy vld empty word expWord maskW pop
    vecs[0]  = mkVec(1, 25'h100,  0, -1, 7, 4'b0011, 32'h11223344, 32'h0, 0, 0, 1, 0, 0, 7, 32'h00003344, 4'b0011, 2);
    vecs[1]  = mkVec(1, 25'h100,  5, -1, 7, 4'b1100, 32'hAABBCCDD, 32'h0, 0, 0, 1, 0, 0, 7, 32'hAABB3344, 4'b1111, 4);
    vecs[2]  = mkVec(1, 25'h100, 31, -1, 0, 4'b1000, 32'h5A000000, 32'h0, 1, 0, 1, 1, 0, 0, 32'h5A000000, 4'b1000, 5);
    vecs[3]  = mkVec(0, 25'h100, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 1, 0, 7, 32'hAABB3344, 4'b1111, 5);
    vecs[4]  = mkVec(0, 25'h100, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 1, 0, 1, 7, 32'h0, 4'b0000, 0);
    vecs[5]  = mkVec(0, 25'h100, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 1, 0, 1, 0, 1, 7, 32'h0, 4'b0000, 0);
    vecs[6]  = mkVec(1, 25'h200, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0, 1, 0, 32'h0, 4'b0000, 0);
    vecs[7]  = mkVec(1, 25'h300,  2,  9, 4, 4'b0110, 32'h01020304, 32'hA0B0C0D0, 0, 0, 1, 0, 0, 4, 32'h00B0C000, 4'b0110, 2);
    vecs[8]  = mkVec(1, 25'h300, 20,  1, 4, 4'b1001, 32'h11111111, 32'h22222222, 0, 0, 1, 0, 0, 4, 32'h11B0C011, 4'b1111, 4);
    vecs[9]  = mkVec(0, 25'h300, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 1, 0, 1, 1, 0, 4, 32'h11B0C011, 4'b1111, 4);
    vecs[10] = mkVec(0, 25'h300, -1, -1, 0, 4'b0000, 32'h0, 32'h0, 0, 1, 1, 0, 1, 4, 32'h0, 4'b0000, 0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clearIn();
      in_valid_i     = vecs[i].vld;
      in_blockAddr_i = vecs[i].addr;
      flush_i        = vecs[i].flush;
      out_ready_i    = vecs[i].ordy;
      if (vecs[i].lane >= 0) setLane(vecs[i].lane, vecs[i].offs, vecs[i].oh, vecs[i].dat);
      if (vecs[i].lane2 >= 0) setLane(vecs[i].lane2, vecs[i].offs, vecs[i].oh, vecs[i].dat2);
      #1;
      chk($sformatf("v%0d_rdy", i), 1024'(in_ready_o), 1024'(vecs[i].expRdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 1024'(out_valid_o), 1024'(vecs[i].expVld));
      chk($sformatf("v%0d_empty", i), 1024'(empty_o), 1024'(vecs[i].expEmpty));
      chkLine($sformatf("v%0d", i), vecs[i].word, vecs[i].expWord, vecs[i].expMaskW, vecs[i].expPop);
    end

    // Partial store with no follow-up drains on idle timeout.
    @(negedge clk);
    clearIn();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_blockAddr_i = 25'h100;
    setLane(3, 7, 4'b0011, 32'hAABBCCDD);
    @(posedge clk);
    riseAt = -1;
    for (int i = 1; i <= 20 && riseAt < 0; i++) begin
      @(negedge clk);
      clearIn();
      @(posedge clk);
      #1;
      if (out_valid_o) riseAt = i;
    end
    chk("timeout_edges", 1024'(riseAt), 1024'(15));
    chk("timeout_addr", 1024'(out_blockAddr_o), 1024'(25'h100));
    chkLine("timeout", 7, 32'h0000CCDD, 4'b0011, 2);
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("timeout_drained", 1024'(empty_o), 1024'(1'b1));

    // Full-line store drains on the next edge.
    @(negedge clk);
    clearIn();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_blockAddr_i = 25'h0AB;
    for (int l = 0; l < 32; l++) setLane(l, l, 4'hF, 32'h10000000 + 32'(l));
    #1;
    chk("full_rdy", 1024'(in_ready_o), 1024'(1'b1));
    @(posedge clk);
    #1;
    chk("full_valid", 1024'(out_valid_o), 1024'(1'b1));
    chkLine("full", 31, 32'h1000001F, 4'hF, 128);
    @(negedge clk);
    clearIn();
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("full_drained", 1024'(empty_o), 1024'(1'b1));

    // Address change: old line drains, new request handed off in DRAIN.
    @(negedge clk);
    clearIn();
    in_valid_i = 1'b1;
    in_blockAddr_i = 25'h100;
    setLane(0, 0, 4'hF, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    clearIn();
    in_valid_i = 1'b1;
    in_blockAddr_i = 25'h101;
    setLane(1, 1, 4'hF, 32'h12345678);
    out_ready_i = 1'b1;
    #1;
    chk("hand_rdy_merge", 1024'(in_ready_o), 1024'(1'b0));
    @(posedge clk);
    #1;
    chk("hand_valid", 1024'(out_valid_o), 1024'(1'b1));
    chk("hand_old_addr", 1024'(out_blockAddr_o), 1024'(25'h100));
    chkLine("hand_old", 0, 32'hCAFEF00D, 4'hF, 4);
    chk("hand_rdy_drain", 1024'(in_ready_o), 1024'(1'b1));
    @(posedge clk);
    #1;
    chk("hand_new_valid", 1024'(out_valid_o), 1024'(1'b0));
    chk("hand_new_empty", 1024'(empty_o), 1024'(1'b0));
    chk("hand_new_addr", 1024'(out_blockAddr_o), 1024'(25'h101));
    chkLine("hand_new", 1, 32'h12345678, 4'hF, 4);
    chk("hand_new_w0", 1024'(out_data_o[31:0]), 1024'h0);

    // Backpressure: line held stable in DRAIN while out_ready_i is low.
    @(negedge clk);
    clearIn();
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clearIn();
    @(posedge clk);
    @(negedge clk);
    clearIn();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_blockAddr_i = 25'h200;
    setLane(4, 10, 4'b0101, 32'h99887766);
    @(posedge clk);
    @(negedge clk);
    clearIn();
    flush_i = 1'b1;
    in_blockAddr_i = 25'h200;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clearIn();
      in_valid_i = 1'b1;
      in_blockAddr_i = 25'h222;
      setLane(0, 0, 4'hF, 32'h0BADBEEF);
      #1;
      chk($sformatf("bp%0d_rdy", i), 1024'(in_ready_o), 1024'(1'b0));
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", i), 1024'(out_valid_o), 1024'(1'b1));
      chk($sformatf("bp%0d_addr", i), 1024'(out_blockAddr_o), 1024'(25'h200));
      chkLine($sformatf("bp%0d", i), 10, 32'h00880066, 4'b0101, 2);
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_addr", 1024'(out_blockAddr_o), 1024'(25'h222));
    chk("bp_handoff_valid", 1024'(out_valid_o), 1024'(1'b0));

    // Reset while draining discards the line.
    @(negedge clk);
    clearIn();
    out_ready_i = 1'b0;
    flush_i = 1'b1;
    in_blockAddr_i = 25'h222;
    @(posedge clk);
    #1;
    chk("rd_valid_pre", 1024'(out_valid_o), 1024'(1'b1));
    @(negedge clk);
    clearIn();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_valid", 1024'(out_valid_o), 1024'(1'b0));
    chk("rd_empty", 1024'(empty_o), 1024'(1'b1));
    chk("rd_mask", 1024'(out_byteMask_o), 1024'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
